// File: rtl/bitstream_decoder.sv
// Stochastic bitstream decoder: counts 1s per channel over a 2**WINDOW_BITS sample window.
// Optional BITSTREAM_DECODER_BIPOLAR_EN selects two's complement bipolar results.
module bitstream_decoder #(
  parameter int CHANNELS    = 2,
  parameter int WINDOW_BITS = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                stream_valid,
  input  logic [CHANNELS-1:0]                 stream_in,
  output logic                                busy,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CHANNELS*(WINDOW_BITS+2)-1:0] out_value
);

  localparam int OUT_W = WINDOW_BITS + 2;
  localparam int CW    = WINDOW_BITS + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] win_cnt;
  logic [CW-1:0] cnt [CHANNELS];
  logic          win_full;
  logic          clr;
  logic          take;
  logic          load;
  logic [CHANNELS*OUT_W-1:0] res;

  // MSB of the window counter is set only once the full window is in
  assign win_full  = win_cnt[WINDOW_BITS];
  assign busy      = (state == ACCUM);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    take      = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          clr       = 1'b1;
        end
      end
      ACCUM: begin
        if (win_full) begin
          state_nxt = DONE;
          load      = 1'b1;
        end else begin
          take = stream_valid;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (start) begin
            state_nxt = ACCUM;
            clr       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res = '0;
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
      res[i*OUT_W +: OUT_W] = {cnt[i], 1'b0}
        - {2'b01, {WINDOW_BITS{1'b0}}};
`else
      res[i*OUT_W +: OUT_W] = {1'b0, cnt[i]};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      win_cnt   <= '0;
      out_value <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (clr) begin
        win_cnt <= '0;
        for (int i = 0; i < CHANNELS; i++) begin
          cnt[i] <= '0;
        end
      end else if (take) begin
        win_cnt <= win_cnt + CW'(1);
        for (int i = 0; i < CHANNELS; i++) begin
          cnt[i] <= cnt[i] + {{WINDOW_BITS{1'b0}}, stream_in[i]};
        end
      end
      if (load) begin
        out_value <= res;
      end
    end
  end

endmodule

// File: tb/tb_bitstream_decoder.sv
// Randomized self-checking bench for bitstream_decoder (CHANNELS=2, WINDOW_BITS=4).
// Expected results come from counting the bench's own driven samples.
module tb_bitstream_decoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stream_valid;
  logic [1:0]  stream_in;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_value;

  int tests;
  int fails;
  int xfers;

  bitstream_decoder #(
    .CHANNELS(2),
    .WINDOW_BITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stream_valid(stream_valid),
    .stream_in(stream_in),
    .busy(busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_value(out_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) xfers++;
  end

  function automatic logic [5:0] exp_val(input int c);
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
    return 6'(2 * c - 16);
`else
    return 6'(c);
`endif
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the negedge right after the start edge.
  task automatic feed(input int pat, input bit stalls, input string nm);
    int n, got, c0, c1, lat;
    bit v;
    logic [1:0] d;
    logic [11:0] expv;
    n = 0; got = 0; c0 = 0; c1 = 0; lat = 0;
    while (got < 16) begin
      v = stalls ? (n % 2 == 0) : 1'b1;
      if (v) begin
        case (pat)
          0: d = 2'b01;
          1: d = {got % 4 == 0, got % 2 == 0};
          default: d = 2'($urandom);
        endcase
        c0 += int'(d[0]);
        c1 += int'(d[1]);
        got++;
        lat = n + 2;
      end else begin
        d = 2'b11;
      end
      stream_valid = v;
      stream_in = d;
      if (n == 5) begin
        tests++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL %s busy: got %b want 1", nm, busy);
        end
      end
      @(negedge clk);
      n++;
    end
    stream_valid = 1'b0;
    stream_in = 2'($urandom);
    while (out_valid !== 1'b1 && n < lat + 20) begin
      @(negedge clk);
      n++;
    end
    expv = {exp_val(c1), exp_val(c0)};
    tests++;
    if (n !== lat) begin
      fails++;
      $display("FAIL %s latency: got %0d want %0d", nm, n, lat);
    end
    tests++;
    if (out_value !== expv) begin
      fails++;
      $display("FAIL %s value: got %h want %h (c0=%0d c1=%0d)",
               nm, out_value, expv, c0, c1);
    end
  endtask

  task automatic consume(input string nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s consume: got valid=%b busy=%b want 0 0",
               nm, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_value !== 12'h0) begin
      fails++;
      $display("FAIL reset_init: got busy=%b valid=%b value=%h want 0 0 0",
               busy, out_valid, out_value);
    end
    rst = 1'b0;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      stream_valid = 1'b1;
      stream_in = 2'b11;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_value !== 12'h0) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b valid=%b value=%h want 0 0 0",
               busy, out_valid, out_value);
    end
    @(negedge clk);
    rst = 1'b0;
    stream_valid = 1'b0;
    pulse_start();
    feed(2, 1'b0, "after_reset");
    consume("after_reset");
  endtask

  task automatic test_constant();
    pulse_start();
    feed(0, 1'b0, "constant");
    consume("constant");
  endtask

  task automatic test_pattern();
    pulse_start();
    feed(1, 1'b0, "pattern");
    consume("pattern");
  endtask

  task automatic test_stalls();
    pulse_start();
    feed(2, 1'b1, "stalls");
    consume("stalls");
  endtask

  task automatic test_backpressure();
    logic [11:0] held;
    int bad;
    pulse_start();
    feed(2, 1'b0, "bp");
    held = out_value;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      start = 1'($urandom);
      @(negedge clk);
      if (out_valid !== 1'b1 || busy !== 1'b0 || out_value !== held) bad++;
    end
    start = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: got %0d bad cycles, value=%h want 0, %h",
               bad, out_value, held);
    end
    consume("bp");
  endtask

  task automatic test_back_to_back();
    int x0;
    pulse_start();
    feed(2, 1'b0, "b2b_first");
    x0 = xfers;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_restart: got busy=%b valid=%b want 1 0",
               busy, out_valid);
    end
    feed(2, 1'b0, "b2b_second");
    consume("b2b_second");
    tests++;
    if (xfers - x0 != 2) begin
      fails++;
      $display("FAIL b2b_xfers: got %0d want 2", xfers - x0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      pulse_start();
      feed(2, 1'($urandom), "random");
      consume("random");
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    xfers = 0;
    rst = 1'b1;
    start = 1'b0;
    stream_valid = 1'b0;
    stream_in = 2'b00;
    out_ready = 1'b0;
    test_reset();
    test_constant();
    test_pattern();
    test_stalls();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
